led_pattern_gen: RTL and testbench

- Parametrised LED sequencer that drives LED_W board LEDs with one of four selectable patterns: chase, bounce, binary count and blink.
- A programmable step timer sets the pattern rate, and a 2-bit speed input scales it at run time.
- Adds pause, a one-cycle step strobe and clean mode switching.
- Sits directly between board inputs (switches/keys, already synchronised upstream) and the LED pins.

---
 rtl/led_pattern_gen.sv | 101 ++++++++++
 tb/tb_led_pattern_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED sequencer: chase/bounce/count/blink at a programmable step rate with pause.
// led and step are registered; reload lands 1 cycle after rst or a mode change; no backpressure.
module led_pattern_gen #(
  parameter int LED_W       = 4,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int TIMER_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {CHASE = 2'd0, BOUNCE = 2'd1, COUNT = 2'd2, BLINK = 2'd3} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [TIMER_W-1:0] STEP_P = TIMER_W'(STEP_CYCLES);

  logic [LED_W-1:0]   led_q, led_d;
  logic               step_q, step_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  dir_e               dir_q, dir_d;
  mode_e              mode_q, mode_d;
  logic               pend_q, pend_d;

  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] period_m1;
  logic [LED_W-1:0]   bounce_nxt;
  logic               reload;

  function automatic logic [LED_W-1:0] init_led(input mode_e m);
    case (m)
      CHASE, BOUNCE: init_led = LED_W'(1);
      COUNT:         init_led = '0;
      default:       init_led = '1;
    endcase
  endfunction

  assign period    = STEP_P >> speed;
  assign period_m1 = period - TIMER_W'(1);
  assign reload    = pend_q || (mode_e'(mode) != mode_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      step_q  <= 1'b0;
      timer_q <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= CHASE;
      pend_q  <= 1'b1;
    end else begin
      led_q   <= led_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    led_d      = led_q;
    step_d     = 1'b0;
    timer_d    = timer_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    pend_d     = 1'b0;
    bounce_nxt = (dir_q == DIR_UP) ? (led_q << 1) : (led_q >> 1);
    if (reload) begin
      mode_d  = mode_e'(mode);
      timer_d = '0;
      dir_d   = DIR_UP;
      led_d   = init_led(mode_e'(mode));
    end else if (en) begin
      // >= rather than == so a faster speed never strands the timer past its period
      if (timer_q >= period_m1) begin
        timer_d = '0;
        step_d  = 1'b1;
        case (mode_q)
          CHASE:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          BOUNCE: begin
            led_d = bounce_nxt;
            if (dir_q == DIR_UP && bounce_nxt[LED_W-1]) dir_d = DIR_DOWN;
            if (dir_q == DIR_DOWN && bounce_nxt[0])     dir_d = DIR_UP;
          end
          COUNT:   led_d = led_q + LED_W'(1);
          default: led_d = ~led_q;
        endcase
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_W=4, STEP_CYCLES=8.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [3:0] led;
  logic       step;

  int errors = 0;
  int checks = 0;

  led_pattern_gen #(.LED_W(4), .STEP_CYCLES(8), .TIMER_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .led(led), .step(step)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_led, input logic exp_step);
    checks++;
    assert (led === exp_led) else begin
      errors++;
      $error("FAIL %s led: got %b expected %b", tag, led, exp_led);
    end
    checks++;
    assert (step === exp_step) else begin
      errors++;
      $error("FAIL %s step: got %b expected %b", tag, step, exp_step);
    end
  endtask

  // led must hold for p-1 cycles with step low, then change with step high
  task automatic step_to(input string tag, input int p, input logic [3:0] prev, input logic [3:0] nxt);
    cyc(p - 1);
    chk({tag, "_hold"}, prev, 1'b0);
    cyc(1);
    chk({tag, "_step"}, nxt, 1'b1);
  endtask

  logic [3:0] cnt;

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0; speed = 2'd0;
    cyc(3);
    chk("reset", 4'b0000, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("chase_init", 4'b0001, 1'b0);
    step_to("chase1", 8, 4'b0001, 4'b0010);
    step_to("chase2", 8, 4'b0010, 4'b0100);
    step_to("chase3", 8, 4'b0100, 4'b1000);
    step_to("chase4", 8, 4'b1000, 4'b0001);

    rst = 1'b1; mode = 2'd1;
    cyc(1);
    chk("bounce_rst", 4'b0000, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("bounce_init", 4'b0001, 1'b0);
    step_to("bounce1", 8, 4'b0001, 4'b0010);
    step_to("bounce2", 8, 4'b0010, 4'b0100);
    step_to("bounce3", 8, 4'b0100, 4'b1000);
    step_to("bounce4", 8, 4'b1000, 4'b0100);
    step_to("bounce5", 8, 4'b0100, 4'b0010);
    step_to("bounce6", 8, 4'b0010, 4'b0001);
    step_to("bounce7", 8, 4'b0001, 4'b0010);

    mode = 2'd2;
    cyc(1);
    chk("count_init", 4'b0000, 1'b0);
    cnt = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      step_to("count", 8, cnt, cnt + 4'd1);
      cnt = cnt + 4'd1;
    end
    chk("count_wrapped", 4'b0000, 1'b1);

    mode = 2'd3;
    cyc(1);
    chk("blink_init", 4'b1111, 1'b0);
    step_to("blink1", 8, 4'b1111, 4'b0000);
    step_to("blink2", 8, 4'b0000, 4'b1111);
    step_to("blink3", 8, 4'b1111, 4'b0000);

    mode = 2'd0; speed = 2'd2;
    cyc(1);
    chk("speed_init", 4'b0001, 1'b0);
    step_to("speed2_a", 2, 4'b0001, 4'b0010);
    step_to("speed2_b", 2, 4'b0010, 4'b0100);
    speed = 2'd0;
    cyc(5);
    chk("timer5", 4'b0100, 1'b0);
    speed = 2'd3;
    cyc(1);
    chk("speed3_immediate", 4'b1000, 1'b1);
    speed = 2'd0;
    cyc(3);
    en = 1'b0;
    cyc(1);
    chk("pause_start", 4'b1000, 1'b0);
    cyc(19);
    chk("pause_end", 4'b1000, 1'b0);
    en = 1'b1;
    cyc(4);
    chk("resume_hold", 4'b1000, 1'b0);
    cyc(1);
    chk("resume_step", 4'b0001, 1'b1);

    cyc(7);
    chk("due_hold", 4'b0001, 1'b0);
    mode = 2'd1;
    cyc(1);
    chk("mode_vs_step", 4'b0001, 1'b0);
    step_to("after_reload", 8, 4'b0001, 4'b0010);
    step_to("b_up2", 8, 4'b0010, 4'b0100);
    step_to("b_up3", 8, 4'b0100, 4'b1000);
    step_to("b_down", 8, 4'b1000, 4'b0100);
    rst = 1'b1;
    cyc(1);
    chk("midrst", 4'b0000, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("midrst_init", 4'b0001, 1'b0);
    step_to("midrst_up1", 8, 4'b0001, 4'b0010);
    step_to("midrst_up2", 8, 4'b0010, 4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
